add_seq_ctrl: RTL
=================

Name: add_seq_ctrl

Overview:
- Multi-word operand sequencer and result collector that sits directly around the 16-bit combinational ripple-carry adder.
- Accepts wide operands over a valid/ready handshake and drives them into the adder one 16-bit word at a time, least-significant word first.
- Waits a fixed settle time for each word, then captures the adder's sum and carry.
- Chains each captured carry into the next word, and presents the full-width result over a second valid/ready handshake.

Parameters:
- WORDS, 2: number of 16-bit words per operand (legal range 1..4); data width DW = 16*WORDS.
- SETTLE_CYCLES, 2: cycles each word's operands are held stable before the adder output is sampled (minimum 1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept operands.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- in_cin  in  1  carry-in to word 0.
- op_a  out  16  current A word, to adder A.
- op_b  out  16  current B word, to adder B.
- op_cin  out  1  current carry-in, to adder carry_in.
- add_sum  in  16  adder Sum.
- add_cout  in  1  adder carry_out.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  DW  full-width sum.
- res_cout  out  1  carry out of the top word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, word index = 0, settle counter = 0.
  - op_a, op_b, op_cin, res_sum and res_cout are all 0; res_valid = 0.
  - in_ready = 1 and busy = 0 once reset is applied.
- Reset mid-operation: the in-flight transaction is dropped with no partial result. The consumer sees no res_valid.
- FSM states: IDLE, SETTLE, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_a, in_b, in_cin; load op_a/op_b with word 0 and op_cin with in_cin; clear the result register; go to SETTLE with word index 0 and counter 0.
- SETTLE:
  - in_ready = 0; op_* stay stable.
  - Counter increments every cycle. When counter == SETTLE_CYCLES-1, that edge does the following:
    - Capture add_sum into res_sum word[index].
    - If index == WORDS-1: capture add_cout into res_cout and go to DONE.
    - Otherwise: increment index; load op_a/op_b with the next word; load op_cin with add_cout; reset counter to 0.
- DONE:
  - res_valid = 1; res_sum and res_cout are held stable while res_ready is low.
  - On res_ready: go to IDLE; res_valid deasserts on the next cycle.
  - res_sum and res_cout keep their last value until the next transaction starts.
- Latency: res_valid rises exactly WORDS*SETTLE_CYCLES cycles after the accept edge.
  - Example: WORDS=2, SETTLE_CYCLES=2 gives 4 cycles.
  - Throughput is at most one transaction per WORDS*SETTLE_CYCLES+2 cycles.
- Input handling:
  - The input handshake is ignored outside IDLE, and in_a/in_b may change freely after accept.
  - Operands are never accepted in the same cycle as a result handoff.
- Arithmetic: res_sum = (in_a + in_b + in_cin) mod 2^DW and res_cout = bit DW of the exact sum. Correctness assumes a correct adder and SETTLE_CYCLES covering the ripple delay.
- Wrap-around: a carry is propagated across every word boundary; no saturation is applied.

Optional Feature:
- Macro: ADD_SEQ_OVF_EN.
- Defined:
  - Adds output port res_ovf (1 bit), the signed two's-complement overflow of the full-width add.
  - res_ovf = (a[DW-1] == b[DW-1]) && (res_sum[DW-1] != a[DW-1]), using the latched operand MSBs.
  - Valid with res_valid and held with res_sum; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package add_seq_pkg:
  - constant WORD_W = 16;
  - state typedef (IDLE/SETTLE/DONE);
  - function returning word i of a DW vector.
- One sub-module, add_seq_settle_timer:
  - inputs: load/clear; output: expire pulse at SETTLE_CYCLES-1;
  - shares the clk/rst_n convention.

Test Plan (bench wires the real 16-bit ripple adder between op_*/add_*; WORDS=2, SETTLE_CYCLES=2):
- a=237, b=367, cin=0 -> res_sum=604, res_cout=0, res_valid exactly 4 cycles after accept.
- a=0x0000FFFF, b=0x00000001, cin=0 -> res_sum=0x00010000, res_cout=0 (carry crosses the word boundary).
- a=0xFFFFFFFF, b=0x00000000, cin=1 -> res_sum=0x00000000, res_cout=1.
  - With ADD_SEQ_OVF_EN: a=0x7FFFFFFF, b=1 -> res_ovf=1; a=0xFFFFFFFF, b=1 -> res_ovf=0.
- Back-pressure: hold res_ready=0 for 10 cycles -> res_valid/res_sum stable, in_ready=0, in_valid pulses are ignored. Then res_ready=1 -> IDLE with in_ready=1 the next cycle.
- Assert rst_n low during SETTLE of word 1 -> all outputs are at reset values immediately, no res_valid afterward. A new request then completes correctly (123+723=846).

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the multi-word adder sequencer.
// The optional overflow output (macro ADD_SEQ_OVF_EN) is handled in add_seq_ctrl.
package add_seq_pkg;

    localparam int WORD_W = 16;
    // Widest supported operand (4 words); word_of() works on this width.
    localparam int MAX_W  = 4 * WORD_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Return 16-bit word idx of a (zero-extended) wide vector.
    function automatic logic [WORD_W-1:0] word_of(input logic [MAX_W-1:0] vec,
                                                  input int unsigned idx);
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/add_seq_settle_timer.sv
// Settle timer: counts cycles while running and pulses o_expire on the
// cycle the count reaches SETTLE_CYCLES-1, then restarts from zero.
module add_seq_settle_timer
    import add_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expire
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_expire;

    assign w_expire = i_run && (r_cnt == LAST);
    assign o_expire = w_expire;

    // Cycle counter: cleared outside a settle window and on every expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || w_expire) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-word operand sequencer around a 16-bit combinational adder.
// Feeds operands LS word first, waits SETTLE_CYCLES per word, chains the
// carry and returns the full-width result on a valid/ready handshake.
// Optional: define ADD_SEQ_OVF_EN to add the signed-overflow output res_ovf.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WORDS         = 2,
    parameter int SETTLE_CYCLES = 2,
    localparam int DW           = WORD_W * WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DW-1:0]     in_a,
    input  logic [DW-1:0]     in_b,
    input  logic              in_cin,
    output logic [WORD_W-1:0] op_a,
    output logic [WORD_W-1:0] op_b,
    output logic              op_cin,
    input  logic [WORD_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_sum,
    output logic              res_cout,
`ifdef ADD_SEQ_OVF_EN
    output logic              res_ovf,
`endif
    output logic              busy
);

    localparam logic [1:0] LAST_IDX = 2'(WORDS - 1);

    state_t            r_state;
    logic [1:0]        r_idx;
    logic [DW-1:0]     r_a;
    logic [DW-1:0]     r_b;
    logic [WORD_W-1:0] r_op_a;
    logic [WORD_W-1:0] r_op_b;
    logic              r_op_cin;
    logic [DW-1:0]     r_res_sum;
    logic              r_res_cout;
    logic              r_res_valid;
    logic              r_in_ready;
    logic              r_busy;
    logic              r_ovf;

    logic              w_accept;
    logic              w_expire;
    logic              w_last_word;

    assign w_accept    = r_in_ready && in_valid;
    assign w_last_word = (r_idx == LAST_IDX);

    assign in_ready  = r_in_ready;
    assign op_a      = r_op_a;
    assign op_b      = r_op_b;
    assign op_cin    = r_op_cin;
    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_cout  = r_res_cout;
    assign busy      = r_busy;
`ifdef ADD_SEQ_OVF_EN
    assign res_ovf   = r_ovf;
`endif

    add_seq_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != SETTLE),
        .i_run    (r_state == SETTLE),
        .o_expire (w_expire)
    );

    // Operand capture: plain data, only meaningful while a transaction runs.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= in_a;
            r_b <= in_b;
        end
    end

    // Sequencer FSM with registered handshake, adder-drive and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_cin    <= 1'b0;
            r_res_sum   <= '0;
            r_res_cout  <= 1'b0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= SETTLE;
                        r_idx      <= '0;
                        r_op_a     <= in_a[WORD_W-1:0];
                        r_op_b     <= in_b[WORD_W-1:0];
                        r_op_cin   <= in_cin;
                        r_res_sum  <= '0;
                        r_res_cout <= 1'b0;
                        r_ovf      <= 1'b0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_expire) begin
                        r_res_sum[r_idx*WORD_W +: WORD_W] <= add_sum;
                        if (w_last_word) begin
                            r_res_cout  <= add_cout;
                            // Signed overflow: equal operand signs, differing result sign.
                            r_ovf       <= (r_a[DW-1] == r_b[DW-1]) &&
                                           (add_sum[WORD_W-1] != r_a[DW-1]);
                            r_res_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_idx    <= r_idx + 1'b1;
                            r_op_a   <= word_of(MAX_W'(r_a), 32'(r_idx) + 32'd1);
                            r_op_b   <= word_of(MAX_W'(r_b), 32'(r_idx) + 32'd1);
                            r_op_cin <= add_cout;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_idx       <= '0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
